// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector: KMP prefix-state tracker with overlap / non-overlap
// restart, Mealy or Moore match flag, and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned       PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b1101,
  parameter bit                OVERLAP = 1'b1,
  parameter bit                MEALY   = 1'b1,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic                         cp,
  input  logic                         rd,
  input  logic                         en,
  input  logic                         x,
  input  logic                         clr,
  output logic                         z,
  output logic [$clog2(PAT_W+1)-1:0]   st,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int unsigned      StW    = $clog2(PAT_W + 1);
  localparam int unsigned      TblN   = 1 << StW;
  localparam logic [StW-1:0]   LastSt = StW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  // Longest k < PAT_W such that the first k pattern bits equal the last k bits of
  // (first s pattern bits, b). On a full match this yields the longest proper border.
  function automatic int unsigned kmp_next(int unsigned s, bit b);
    int unsigned best;
    int unsigned pos;
    bit          ok;
    bit          sb;
    best = 0;
    for (int unsigned k = 1; k <= s + 1; k++) begin
      if (k < PAT_W) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < k; i++) begin
          pos = s + 1 - k + i;
          sb  = (pos == s) ? b : PATTERN[PAT_W - 1 - pos];
          if (sb != PATTERN[PAT_W - 1 - i]) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  logic [TblN-1:0][StW-1:0] nxt0;
  logic [TblN-1:0][StW-1:0] nxt1;

  for (genvar g = 0; g < TblN; g++) begin : g_nxt
    if (g < PAT_W) begin : g_live
      localparam int unsigned N0 = kmp_next(g, 1'b0);
      localparam int unsigned N1 = kmp_next(g, 1'b1);
      assign nxt0[g] = StW'(N0);
      assign nxt1[g] = StW'(N1);
    end else begin : g_pad
      assign nxt0[g] = '0;
      assign nxt1[g] = '0;
    end
  end

  logic [StW-1:0]   st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;
  logic             hit;

  always_comb begin
    hit   = (st_q == LastSt) && (x == PATTERN[0]);
    st_d  = st_q;
    cnt_d = cnt_q;
    z_d   = z_q;
    if (rd) begin
      st_d  = '0;
      cnt_d = '0;
      z_d   = 1'b0;
    end else begin
      z_d = en & hit;
      if (en) begin
        if (hit && !OVERLAP) begin
          st_d = '0;
        end else begin
          st_d = x ? nxt1[st_q] : nxt0[st_q];
        end
      end
      // clr acts regardless of en and beats a same-edge increment
      if (clr) begin
        cnt_d = '0;
      end else if (en && hit && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge cp) begin
    st_q  <= st_d;
    cnt_q <= cnt_d;
    z_q   <= z_d;
  end

  assign z         = MEALY ? (en & ~rd & hit) : (z_q & ~rd);
  assign st        = st_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: four parameterisations driven in parallel, checked against a
// history-based string-matching model.
module tb_seq_detect_param;

  localparam int NCfg = 4;

  logic cp = 1'b0;
  logic rd, en, x, clr;

  logic       z0, z1, z2, z3;
  logic [2:0] st0, st1, st3;
  logic [1:0] st2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [2:0] cnt3;

  logic [31:0] st_a  [NCfg];
  logic [31:0] cnt_a [NCfg];
  logic        z_a   [NCfg];

  always #5 cp = ~cp;

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .MEALY(1'b1), .CNT_W(8))
    u_c0 (.cp(cp), .rd(rd), .en(en), .x(x), .clr(clr), .z(z0), .st(st0), .match_cnt(cnt0));
  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .MEALY(1'b0), .CNT_W(8))
    u_c1 (.cp(cp), .rd(rd), .en(en), .x(x), .clr(clr), .z(z1), .st(st1), .match_cnt(cnt1));
  seq_detect_param #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(1'b1), .MEALY(1'b0), .CNT_W(2))
    u_c2 (.cp(cp), .rd(rd), .en(en), .x(x), .clr(clr), .z(z2), .st(st2), .match_cnt(cnt2));
  seq_detect_param #(.PAT_W(6), .PATTERN(6'b101101), .OVERLAP(1'b0), .MEALY(1'b1), .CNT_W(3))
    u_c3 (.cp(cp), .rd(rd), .en(en), .x(x), .clr(clr), .z(z3), .st(st3), .match_cnt(cnt3));

  assign z_a[0] = z0;  assign st_a[0] = 32'(st0);  assign cnt_a[0] = 32'(cnt0);
  assign z_a[1] = z1;  assign st_a[1] = 32'(st1);  assign cnt_a[1] = 32'(cnt1);
  assign z_a[2] = z2;  assign st_a[2] = 32'(st2);  assign cnt_a[2] = 32'(cnt2);
  assign z_a[3] = z3;  assign st_a[3] = 32'(st3);  assign cnt_a[3] = 32'(cnt3);

  // Configuration mirror of the instances above
  int          pw    [NCfg];
  logic [31:0] pat   [NCfg];
  bit          ovl   [NCfg];
  bit          mealy [NCfg];
  int          cw    [NCfg];

  // Model: accepted-bit history (newest in bit 0), its length, counter, Moore flag
  logic [31:0] h   [NCfg];
  int          hl  [NCfg];
  int          cnt [NCfg];
  bit          zq  [NCfg];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] msk(int k);
    return (32'd1 << k) - 32'd1;
  endfunction

  function automatic bit would_match(int k);
    logic [31:0] h2;
    h2 = (h[k] << 1) | 32'(x);
    return (hl[k] + 1 >= pw[k]) && ((h2 & msk(pw[k])) == pat[k]);
  endfunction

  function automatic int exp_st(int k);
    int best;
    best = 0;
    for (int j = 1; j < pw[k]; j++) begin
      if (hl[k] >= j && ((h[k] & msk(j)) == (pat[k] >> (pw[k] - j)))) best = j;
    end
    return best;
  endfunction

  function automatic bit exp_z(int k);
    if (rd) return 1'b0;
    if (mealy[k]) return en && would_match(k);
    return zq[k];
  endfunction

  function automatic void model_edge(int k);
    bit m;
    if (rd) begin
      h[k] = '0; hl[k] = 0; cnt[k] = 0; zq[k] = 1'b0;
    end else begin
      m = en && would_match(k);
      if (en) begin
        h[k]  = (h[k] << 1) | 32'(x);
        hl[k] = (hl[k] < 24) ? hl[k] + 1 : 24;
        if (m && !ovl[k]) hl[k] = 0;
      end
      zq[k] = m;
      if (clr) cnt[k] = 0;
      else if (m && cnt[k] < (1 << cw[k]) - 1) cnt[k]++;
    end
  endfunction

  // Drive one cycle away from the active edge, check all outputs, then advance the model
  task automatic step(input bit r, input bit e, input bit xi, input bit c);
    @(negedge cp);
    rd = r; en = e; x = xi; clr = c;
    #1;
    for (int k = 0; k < NCfg; k++) begin
      check_eq($sformatf("c%0d_z", k), 32'(z_a[k]), 32'(exp_z(k)));
      check_eq($sformatf("c%0d_st", k), st_a[k], 32'(exp_st(k)));
      check_eq($sformatf("c%0d_cnt", k), cnt_a[k], 32'(cnt[k]));
    end
    for (int k = 0; k < NCfg; k++) model_edge(k);
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, v[i], 1'b0);
  endtask

  initial begin
    pw[0] = 4; pat[0] = 32'b1101;   ovl[0] = 1'b1; mealy[0] = 1'b1; cw[0] = 8;
    pw[1] = 4; pat[1] = 32'b1101;   ovl[1] = 1'b0; mealy[1] = 1'b0; cw[1] = 8;
    pw[2] = 3; pat[2] = 32'b111;    ovl[2] = 1'b1; mealy[2] = 1'b0; cw[2] = 2;
    pw[3] = 6; pat[3] = 32'b101101; ovl[3] = 1'b0; mealy[3] = 1'b1; cw[3] = 3;
    for (int k = 0; k < NCfg; k++) begin
      h[k] = '0; hl[k] = 0; cnt[k] = 0; zq[k] = 1'b0;
    end
    rd = 1'b1; en = 1'b0; x = 1'b0; clr = 1'b0;
    repeat (2) @(posedge cp);

    // Overlapping vs non-overlapping on 1101101
    step(1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'b1101101, 7);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t1_ovl_cnt", cnt_a[0], 32'd2);
    check_eq("t2_novl_cnt", cnt_a[1], 32'd1);

    // en gaps between pattern bits
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      step(1'b0, 1'b1, pat[0][i], 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_eq("t5_gap_cnt", cnt_a[0], 32'd1);

    // Reset mid-sequence discards the partial match
    step(1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'b110, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    feed(16'b1, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t4_st", st_a[0], 32'd1);
    check_eq("t4_cnt", cnt_a[0], 32'd0);

    // Saturation of the 2-bit counter, then clr with the fifth overlapping match
    step(1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'b111111, 6);
    check_eq("t6_sat", cnt_a[2], 32'd3);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t6_clr", cnt_a[2], 32'd0);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
